pipe_gen: RTL and testbench
===========================

PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 SHALL have parameter SPACING, default 4: empty columns between pipes; legal range 2..15.
REQ-002 SHALL have parameter PIPE_W, default 2: columns per pipe; legal range 1..4.
REQ-003 SHALL have parameter GAP_H, default 4: rows in the opening; legal range 1..5.
REQ-004 SHALL have parameter BIRD_COL, default 4: bird column index; legal range 1..14.
REQ-005 SHALL have port Clock, input, 1: single clock; all logic on its posedge.
REQ-006 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: game running; 0 freezes all state.
REQ-008 SHALL have port tick, input, 1: scroll strobe, one Clock cycle wide.
REQ-009 SHALL have port rnd, input, 3: random value from the 3-bit LFSR output.
REQ-010 SHALL have port col_sel, input, 4: field column to read; 0 is leftmost, 15 is rightmost.
REQ-011 SHALL have port col_data, output, 16: selected column; bit r=1 means pipe pixel at row r.
REQ-012 SHALL have port pipe_passed, output, 1: one-cycle score pulse.

Function
REQ-013 Field SHALL be 16 columns x 16 rows of registers; col_data SHALL be a combinational read of column col_sel.
REQ-014 Advance occurs only on a cycle with tick=1 and enable=1; tick while enable=0 SHALL be ignored with no state change.
REQ-015 On advance: col[i] <= col[i+1] for i=0..14; col[15] <= new column; old col[0] is discarded.
REQ-016 FSM states SHALL be GAP and PIPE; GAP uses gap counter gcnt; PIPE uses pipe counter pcnt.
REQ-017 In GAP, advance SHALL insert 16'h0000; if gcnt==1 go to PIPE, latch gap_base=rnd+4 (4 bits), set pcnt=PIPE_W; otherwise gcnt-1.
REQ-018 In PIPE, advance SHALL insert a column with rows gap_base..gap_base+GAP_H-1 cleared and all other rows set; if pcnt==1 go to GAP with gcnt=current spacing; otherwise pcnt-1.
REQ-019 gap_base SHALL be held for all PIPE_W columns of a pipe; rnd changes during PIPE SHALL have no effect.
REQ-020 All 8 rnd values SHALL be legal; no row index exceeds 15 within the parameter ranges.
REQ-021 A 16-bit tag vector SHALL mark the last column of each pipe and SHALL shift in lockstep with the field.
REQ-022 pipe_passed SHALL be registered and high for exactly the one cycle after an advance that moves a tag into column BIRD_COL-1.
REQ-023 Pipe period SHALL be spacing+PIPE_W advances.

Reset
REQ-024 Reset SHALL clear all field and tag bits, set state=GAP, gcnt=SPACING, spacing=SPACING, gap_base=0, pipe_passed=0, pipe counter=0.
REQ-025 Reset SHALL take priority over a simultaneous tick or enable.
REQ-026 Reset mid-pipe SHALL abandon the partial pipe; the first pipe column SHALL appear on advance SPACING+1 after reset.

Configuration
REQ-027 With macro PIPE_GEN_SPEEDUP_EN defined: an internal pipe counter SHALL count completed pipes, and every 8th completion SHALL decrement spacing by 1, with a floor of 2.
REQ-028 Without PIPE_GEN_SPEEDUP_EN: spacing SHALL stay fixed at SPACING and no pipe counter logic SHALL be built.

Verification (defaults)
REQ-029 Reset, then read col_sel=0..15 -> all col_data=16'h0000 and pipe_passed=0.
REQ-030 Hold rnd=3, enable=1, apply 5 ticks -> col 15=16'hF87F and cols 0..14=0; after tick 6, cols 14 and 15=16'hF87F; after tick 7, col 15=0.
REQ-031 rnd=3 at tick 4, rnd=0 at tick 5 -> cols 14 and 15 = 16'hF87F; next pipe with rnd=0 latched -> 16'hFF0F; with rnd=7 latched -> 16'h87FF.
REQ-032 enable=0 with 10 tick pulses -> field unchanged; Reset asserted with tick on the same cycle after tick 5 -> field cleared; first pipe appears after 5 further advances.
REQ-033 Continuous advances -> pipe_passed high exactly one cycle, the cycle after tick 18; repeats every 6 advances (tick 24, 30, ...).
REQ-034 PIPE_GEN_SPEEDUP_EN defined, 8 pipes completed -> next gap is 3 columns; after 16 pipes -> 2 columns; stays at 2 thereafter.

Source files
------------

// File: rtl/pipe_gen.sv
// Scrolling pipe-field generator: 16x16 register field, GAP/PIPE column FSM, score pulse.
// Optional PIPE_GEN_SPEEDUP_EN: spacing shrinks by one every 8 completed pipes (floor 2).
module pipe_gen #(
  parameter int SPACING  = 4,
  parameter int PIPE_W   = 2,
  parameter int GAP_H    = 4,
  parameter int BIRD_COL = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        enable,
  input  logic        tick,
  input  logic [2:0]  rnd,
  input  logic [3:0]  col_sel,
  output logic [15:0] col_data,
  output logic        pipe_passed
);

  // state | meaning
  // GAP   | inserting empty columns, gcnt counts down the remaining gap
  // PIPE  | inserting pipe columns, pcnt counts down the remaining pipe width
  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_PIPE = 1'b1;

  logic [15:0] field_q [16];
  logic [15:0] tag_q, tag_d;
  logic [0:0]  state_q, state_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [3:0]  gap_base_q, gap_base_d;
  logic        pipe_passed_q;
  logic [15:0] pipe_col, new_col;
  logic        new_tag;
  logic        advance;
  logic        pipe_done;
  logic [3:0]  spacing_d;

  assign advance   = tick & enable;
  assign pipe_done = advance && (state_q == ST_PIPE) && (pcnt_q == 3'd1);
  assign col_data  = field_q[col_sel];
  assign pipe_passed = pipe_passed_q;

`ifdef PIPE_GEN_SPEEDUP_EN
  logic [2:0] npipe_q, npipe_d;
  logic [3:0] spacing_q;

  always_comb begin
    npipe_d   = npipe_q;
    spacing_d = spacing_q;
    if (pipe_done) begin
      npipe_d = npipe_q + 3'd1;
      if (npipe_q == 3'd7 && spacing_q > 4'd2) begin
        spacing_d = spacing_q - 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      npipe_q   <= 3'd0;
      spacing_q <= 4'(SPACING);
    end else begin
      npipe_q   <= npipe_d;
      spacing_q <= spacing_d;
    end
  end
`else
  assign spacing_d = 4'(SPACING);
`endif

  // Opening spans gap_base..gap_base+GAP_H-1; max 11+5-1 stays within row 15.
  always_comb begin
    pipe_col = '1;
    for (int r = 0; r < 16; r++) begin
      if ((r >= int'(gap_base_q)) && (r < int'(gap_base_q) + GAP_H)) begin
        pipe_col[r] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gcnt_d     = gcnt_q;
    pcnt_d     = pcnt_q;
    gap_base_d = gap_base_q;
    new_col    = 16'h0000;
    new_tag    = 1'b0;
    if (advance) begin
      case (state_q)
        ST_GAP: begin
          if (gcnt_q == 4'd1) begin
            state_d    = ST_PIPE;
            gap_base_d = {1'b0, rnd} + 4'd4;
            pcnt_d     = 3'(PIPE_W);
          end else begin
            gcnt_d = gcnt_q - 4'd1;
          end
        end
        default: begin
          new_col = pipe_col;
          if (pcnt_q == 3'd1) begin
            state_d = ST_GAP;
            gcnt_d  = spacing_d;
            new_tag = 1'b1;
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
      endcase
    end
  end

  assign tag_d = {new_tag, 15'b0} | (tag_q >> 1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) field_q[i] <= 16'h0000;
      tag_q         <= 16'h0000;
      state_q       <= ST_GAP;
      gcnt_q        <= 4'(SPACING);
      pcnt_q        <= 3'd0;
      gap_base_q    <= 4'd0;
      pipe_passed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gcnt_q        <= gcnt_d;
      pcnt_q        <= pcnt_d;
      gap_base_q    <= gap_base_d;
      pipe_passed_q <= advance && tag_q[BIRD_COL];
      if (advance) begin
        for (int i = 0; i < 15; i++) field_q[i] <= field_q[i+1];
        field_q[15] <= new_col;
        tag_q       <= tag_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_gen.sv
// Scoreboard bench for pipe_gen (default parameters, speedup disabled).
module tb_pipe_gen;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  rnd = 3'd3;
  logic [3:0]  col_sel = 4'd0;
  logic [15:0] col_data;
  logic        pipe_passed;

  pipe_gen dut (
    .Clock(Clock), .Reset(Reset), .enable(enable), .tick(tick), .rnd(rnd),
    .col_sel(col_sel), .col_data(col_data), .pipe_passed(pipe_passed)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          kind;   // 0: col_data, 1: pipe_passed
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic        chk_req = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          n_adv = 0;
  logic [15:0] pval [16];

  // Monitor: pops an expectation whenever the stimulus flags a sample cycle.
  always @(negedge Clock) begin
    if (chk_req) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: sample requested with empty scoreboard");
      end else begin
        exp_t e;
        logic [15:0] act;
        e = sb.pop_front();
        act = e.kind ? {15'b0, pipe_passed} : col_data;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  // Pipe k occupies insertion ticks 6k+5 and 6k+6 with default parameters.
  function automatic logic [15:0] exp_col(int c);
    int t;
    t = n_adv - (15 - c);
    if (t < 5) return 16'h0000;
    if ((t % 6 == 5) || (t % 6 == 0)) return pval[(t - 5) / 6];
    return 16'h0000;
  endfunction

  function automatic logic exp_pp();
    return (n_adv >= 18) && ((n_adv - 18) % 6 == 0);
  endfunction

  task automatic push_and_sample(bit kind, logic [15:0] v, string nm);
    exp_t e;
    e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
    chk_req = 1'b1;
    @(posedge Clock); #1;
    chk_req = 1'b0;
  endtask

  task automatic chk_col(int c);
    col_sel = 4'(c);
    push_and_sample(1'b0, exp_col(c), $sformatf("col%0d_adv%0d", c, n_adv));
  endtask

  task automatic chk_field();
    for (int c = 0; c < 16; c++) chk_col(c);
  endtask

  // One-cycle tick, then check pipe_passed in the following cycle.
  task automatic adv();
    logic was_en;
    was_en = enable;
    tick = 1'b1;
    @(posedge Clock); #1;
    tick = 1'b0;
    if (was_en) n_adv++;
    push_and_sample(1'b1, {15'b0, was_en && exp_pp()}, $sformatf("pp_adv%0d_en%0d", n_adv, was_en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pval[0] = 16'hF87F;
    pval[1] = 16'hFF0F;
    for (int k = 2; k < 16; k++) pval[k] = 16'h87FF;

    Reset = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    n_adv = 0;
    chk_field();
    push_and_sample(1'b1, 16'h0, "pp_after_reset");

    enable = 1'b1;
    rnd = 3'd3;
    for (int i = 0; i < 4; i++) adv();
    rnd = 3'd0;                    // latched value must hold through the pipe
    adv();
    chk_field();
    adv();
    chk_col(14); chk_col(15);
    adv();
    chk_col(13); chk_col(14); chk_col(15);
    for (int i = 0; i < 5; i++) adv();
    chk_col(14); chk_col(15);
    rnd = 3'd7;
    for (int i = 0; i < 6; i++) adv();
    chk_field();
    for (int i = 0; i < 13; i++) adv();
    chk_field();

    enable = 1'b0;
    for (int i = 0; i < 10; i++) adv();
    chk_field();

    enable = 1'b1;
    for (int i = 0; i < 5; i++) adv();
    tick = 1'b1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    tick = 1'b0;
    Reset = 1'b0;
    n_adv = 0;
    for (int k = 0; k < 16; k++) pval[k] = 16'hFF0F;
    rnd = 3'd0;
    chk_field();
    push_and_sample(1'b1, 16'h0, "pp_after_reset_tick");
    for (int i = 0; i < 4; i++) adv();
    chk_col(15);
    adv();
    chk_col(14); chk_col(15);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clock);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
